// File: rtl/conv_pkg.sv
// Shared definitions for the multi-channel 3x3 convolution engine:
// FSM encoding, data width and output saturation limits.
package conv_pkg;

    localparam int DATA_W = 8;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sh7f;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 8'sh80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/conv_mc_addr_gen.sv
// Window/pixel counters and registered image/weight read addresses.
// The counters always describe the operand pair currently on the read ports.
module conv_mc_addr_gen
    import conv_pkg::*;
#(
    parameter int H      = 28,
    parameter int W      = 28,
    parameter int C      = 1,
    parameter int IMG_AW = 10,
    parameter int WGT_AW = 4,
    parameter int OUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              item_adv,
    input  logic              pix_adv,
    output logic [IMG_AW-1:0] img_addr,
    output logic [WGT_AW-1:0] w_addr,
    output logic [OUT_AW-1:0] out_addr,
    output logic              item_last,
    output logic              pix_last
);

    logic [15:0]       c_q, c_d, i_q, i_d, j_q, j_d;
    logic [1:0]        ki_q, ki_d, kj_q, kj_d;
    logic [IMG_AW-1:0] img_addr_q, img_addr_d;
    logic [WGT_AW-1:0] w_addr_q, w_addr_d;

    // Next counter values: a pixel advance restarts the window at the next output pixel.
    always_comb begin
        c_d  = c_q;
        ki_d = ki_q;
        kj_d = kj_q;
        i_d  = i_q;
        j_d  = j_q;
        if (pix_adv) begin
            c_d  = 16'd0;
            ki_d = 2'd0;
            kj_d = 2'd0;
            if (j_q == 16'(W - 3)) begin
                j_d = 16'd0;
                if (i_q == 16'(H - 3)) begin
                    i_d = 16'd0;
                end else begin
                    i_d = i_q + 16'd1;
                end
            end else begin
                j_d = j_q + 16'd1;
            end
        end else if (item_adv) begin
            if (kj_q == 2'd2) begin
                kj_d = 2'd0;
                if (ki_q == 2'd2) begin
                    ki_d = 2'd0;
                    c_d  = c_q + 16'd1;
                end else begin
                    ki_d = ki_q + 2'd1;
                end
            end else begin
                kj_d = kj_q + 2'd1;
            end
        end else begin
            c_d = c_q;
        end
    end

    // Read addresses follow the next counter values so they register in step.
    always_comb begin
        img_addr_d = IMG_AW'(32'(c_d) * 32'(H * W) + (32'(i_d) + 32'(ki_d)) * 32'(W)
                             + 32'(j_d) + 32'(kj_d));
        w_addr_d   = WGT_AW'(32'(c_d) * 32'd9 + 32'(ki_d) * 32'd3 + 32'(kj_d));
    end

    // Counter and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q        <= 16'd0;
            ki_q       <= 2'd0;
            kj_q       <= 2'd0;
            i_q        <= 16'd0;
            j_q        <= 16'd0;
            img_addr_q <= '0;
            w_addr_q   <= '0;
        end else begin
            c_q        <= c_d;
            ki_q       <= ki_d;
            kj_q       <= kj_d;
            i_q        <= i_d;
            j_q        <= j_d;
            img_addr_q <= img_addr_d;
            w_addr_q   <= w_addr_d;
        end
    end

    assign img_addr  = img_addr_q;
    assign w_addr    = w_addr_q;
    assign out_addr  = OUT_AW'(32'(i_q) * 32'(W - 2) + 32'(j_q));
    assign item_last = (c_q == 16'(C - 1)) && (ki_q == 2'd2) && (kj_q == 2'd2);
    assign pix_last  = (i_q == 16'(H - 3)) && (j_q == 16'(W - 3));

endmodule

// File: rtl/conv_mc.sv
// Multi-channel 3x3 valid convolution with bias, shift, optional ReLU and
// 8-bit saturation; one output pixel per 9*C+2 cycles.
module conv_mc
    import conv_pkg::*;
#(
    parameter int H      = 28,
    parameter int W      = 28,
    parameter int C      = 1,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0,
    parameter int RELU   = 0,
    parameter int IMG_AW = 10,
    parameter int WGT_AW = 4,
    parameter int OUT_AW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     conv,
    output logic [IMG_AW-1:0]        img_addr,
    input  logic signed [DATA_W-1:0] img_data,
    output logic [WGT_AW-1:0]        w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [15:0]       bias,
    output logic signed [DATA_W-1:0] result,
    output logic [OUT_AW-1:0]        address,
    output logic                     store,
    output logic                     done,
    output logic                     busy
);

    localparam bit RELU_EN = (RELU != 0);

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum_s;
    logic signed [15:0]        bias_q, bias_d, prod_s;
    logic signed [DATA_W-1:0]  result_q, result_d;
    logic [OUT_AW-1:0]         address_q, address_d, out_addr_s;
    logic                      store_q, store_d, done_q, done_d, busy_q, busy_d;
    logic                      vld_q, vld_d, last_q, last_d;
    logic                      item_adv_s, pix_adv_s, item_last_s, pix_last_s;

    conv_mc_addr_gen #(
        .H(H), .W(W), .C(C), .IMG_AW(IMG_AW), .WGT_AW(WGT_AW), .OUT_AW(OUT_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .item_adv  (item_adv_s),
        .pix_adv   (pix_adv_s),
        .img_addr  (img_addr),
        .w_addr    (w_addr),
        .out_addr  (out_addr_s),
        .item_last (item_last_s),
        .pix_last  (pix_last_s)
    );

    function automatic logic signed [DATA_W-1:0] shape(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [15:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W-15){b[15]}}, b};
        s = s >>> SHIFT;
        if (RELU_EN && s[ACC_W]) begin
            s = '0;
        end else begin
            s = s;
        end
        if (s > SAT_MAX) begin
            return SAT_MAX;
        end else if (s < SAT_MIN) begin
            return SAT_MIN;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    assign prod_s    = img_data * w_data;
    assign acc_sum_s = acc_q + {{(ACC_W-16){prod_s[15]}}, prod_s};

    // FSM next state; vld_q marks cycles carrying a product for the previous MAC address.
    always_comb begin
        state_d    = state_q;
        bias_d     = bias_q;
        result_d   = result_q;
        address_d  = address_q;
        last_d     = last_q;
        item_adv_s = 1'b0;
        pix_adv_s  = 1'b0;
        vld_d      = (state_q == ST_MAC);
        if (vld_q) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (conv) begin
                    state_d = ST_MAC;
                    bias_d  = bias;
                    acc_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (item_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    item_adv_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d   = ST_STORE;
                pix_adv_s = 1'b1;
                address_d = out_addr_s;
                last_d    = pix_last_s;
                result_d  = shape(acc_sum_s, bias_q);
            end
            ST_STORE: begin
                acc_d = '0;
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        store_d = (state_d == ST_STORE);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            bias_q    <= 16'sd0;
            result_q  <= '0;
            address_q <= '0;
            store_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bias_q    <= bias_d;
            result_q  <= result_d;
            address_q <= address_d;
            store_q   <= store_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    assign result  = result_q;
    assign address = address_q;
    assign store   = store_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
